hazard_scoreboard_unit: RTL and testbench

//  Parametrised successor to the pipeline RAW hazard/forwarding logic. Compares decode-stage (DX)

---
 rtl/hazard_pkg.sv | 30 +++
 rtl/hazard_fwd_match.sv | 43 ++++
 rtl/hazard_scoreboard_unit.sv | 146 ++++++++++++++
 tb/tb_hazard_scoreboard_unit.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared hazard/scoreboard types, register and opcode constants
package hazard_pkg;

  localparam int R_ZERO   = 0;
  localparam int R_STATUS = 30;
  localparam int R_RA     = 31;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_t;

  // Opcodes shared with the decoder; the rs/rt/rd routing of these is done upstream.
  localparam logic [4:0] OP_ALU  = 5'b00000;
  localparam logic [4:0] OP_J    = 5'b00001;
  localparam logic [4:0] OP_BNE  = 5'b00010;
  localparam logic [4:0] OP_JAL  = 5'b00011;
  localparam logic [4:0] OP_JR   = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_BLT  = 5'b00110;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_SETX = 5'b10101;
  localparam logic [4:0] OP_BEX  = 5'b10110;

  function automatic int sel_width(input int n_stages);
    return $clog2(n_stages + 1);
  endfunction

endpackage

// File: rtl/hazard_fwd_match.sv
// rtl/hazard_fwd_match.sv - one DX operand against all in-flight write stages
// Returns the nearest matching stage as a bypass select and flags a load still in stage 1.
module hazard_fwd_match
  import hazard_pkg::*;
#(
  parameter int FWD_STAGES = 2,
  parameter int RW         = 5,
  parameter int SELW       = sel_width(FWD_STAGES)
) (
  input  logic [RW-1:0]            op_addr,
  input  logic                     op_used,
  input  logic [FWD_STAGES-1:0]    wr_valid,
  input  logic [FWD_STAGES*RW-1:0] wr_addr,
  input  logic [FWD_STAGES-1:0]    wr_ovf,
  input  logic [FWD_STAGES-1:0]    wr_is_load,
  output logic [SELW-1:0]          sel,
  output logic                     load_use
);

  logic [FWD_STAGES-1:0] hit;

  for (genvar k = 0; k < FWD_STAGES; k++) begin : g_stage
    logic [RW-1:0] eff_addr;
    assign eff_addr = wr_ovf[k] ? RW'(R_STATUS) : wr_addr[k*RW +: RW];
    assign hit[k]   = op_used & wr_valid[k] & (eff_addr != '0) & (eff_addr == op_addr);
  end

  // Loads are only bypassable once they reach stage 2, so deeper load flags are irrelevant here.
  if (FWD_STAGES > 1) begin : g_deep_load
    logic unused_deep_load;
    assign unused_deep_load = ^wr_is_load[FWD_STAGES-1:1];
  end

  always_comb begin
    sel = '0;
    for (int k = FWD_STAGES - 1; k >= 0; k--) begin
      if (hit[k]) sel = SELW'(k + 1);
    end
    load_use = hit[0] & wr_is_load[0];
    if (load_use) sel = '0;
  end

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// rtl/hazard_scoreboard_unit.sv - RAW bypass selects, register scoreboard and mult/div stall engine
// Optional HAZARD_STATS_EN adds saturating stall / forward cycle counters.
module hazard_scoreboard_unit
  import hazard_pkg::*;
#(
  parameter int FWD_STAGES = 2,
  parameter int NREG       = 32,
  parameter int RW         = 5,
  parameter int MD_TIMEOUT = 40,
  parameter int SELW       = sel_width(FWD_STAGES)
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [RW-1:0]            dx_rs,
  input  logic [RW-1:0]            dx_rt,
  input  logic                     dx_rs_used,
  input  logic                     dx_rt_used,
  input  logic                     dx_wr_valid,
  input  logic [RW-1:0]            dx_rd,
  input  logic                     md_issue,
  input  logic                     md_done,
  input  logic [FWD_STAGES-1:0]    wr_valid,
  input  logic [FWD_STAGES*RW-1:0] wr_addr,
  input  logic [FWD_STAGES-1:0]    wr_ovf,
  input  logic [FWD_STAGES-1:0]    wr_is_load,
  output logic [SELW-1:0]          fwd_sel_rs,
  output logic [SELW-1:0]          fwd_sel_rt,
  output logic                     stall,
  output logic [RW-1:0]            md_rd_o,
  output logic                     md_busy,
  output logic                     md_timeout
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]              stat_stall_cnt,
  output logic [31:0]              stat_fwd_cnt
`endif
);

  localparam int CW = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [0:0] S_IDLE = IDLE;
  localparam logic [0:0] S_BUSY = BUSY;

  logic [NREG-1:0] pending_q, pending_d;
  logic [0:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [RW-1:0]   md_rd_q, md_rd_d;
  logic            md_timeout_q, md_timeout_d;

  logic lu_rs, lu_rt, raw_pending, waw_pending, md_block;

  hazard_fwd_match #(.FWD_STAGES(FWD_STAGES), .RW(RW), .SELW(SELW)) u_match_rs (
    .op_addr(dx_rs), .op_used(dx_rs_used), .wr_valid(wr_valid), .wr_addr(wr_addr),
    .wr_ovf(wr_ovf), .wr_is_load(wr_is_load), .sel(fwd_sel_rs), .load_use(lu_rs)
  );

  hazard_fwd_match #(.FWD_STAGES(FWD_STAGES), .RW(RW), .SELW(SELW)) u_match_rt (
    .op_addr(dx_rt), .op_used(dx_rt_used), .wr_valid(wr_valid), .wr_addr(wr_addr),
    .wr_ovf(wr_ovf), .wr_is_load(wr_is_load), .sel(fwd_sel_rt), .load_use(lu_rt)
  );

  always_comb begin
    raw_pending = (dx_rs_used & pending_q[dx_rs]) | (dx_rt_used & pending_q[dx_rt]);
    waw_pending = dx_wr_valid & pending_q[dx_rd];
    md_block    = md_issue & (state_q == S_BUSY);
    stall       = lu_rs | lu_rt | raw_pending | waw_pending | md_block;
  end

  // A done and a new issue never share a cycle: any issue while BUSY is stalled by md_block.
  always_comb begin
    pending_d    = pending_q;
    state_d      = state_q;
    cnt_d        = cnt_q;
    md_rd_d      = md_rd_q;
    md_timeout_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (md_issue && !stall && (dx_rd != '0)) begin
          pending_d[dx_rd] = 1'b1;
          md_rd_d          = dx_rd;
          cnt_d            = '0;
          state_d          = S_BUSY;
        end
      end
      default: begin
        if (md_done) begin
          pending_d[md_rd_q] = 1'b0;
          state_d            = S_IDLE;
        end else if (cnt_q == CW'(MD_TIMEOUT - 1)) begin
          pending_d[md_rd_q] = 1'b0;
          md_timeout_d       = 1'b1;
          state_d            = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    endcase
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending_q    <= '0;
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      md_rd_q      <= '0;
      md_timeout_q <= 1'b0;
    end else begin
      pending_q    <= pending_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      md_rd_q      <= md_rd_d;
      md_timeout_q <= md_timeout_d;
    end
  end

  assign md_rd_o    = md_rd_q;
  assign md_busy    = (state_q == S_BUSY);
  assign md_timeout = md_timeout_q;

`ifdef HAZARD_STATS_EN
  logic [31:0] stat_stall_q, stat_stall_d, stat_fwd_q, stat_fwd_d;
  logic        any_fwd;

  always_comb begin
    any_fwd      = (fwd_sel_rs != '0) | (fwd_sel_rt != '0);
    stat_stall_d = stat_stall_q;
    stat_fwd_d   = stat_fwd_q;
    if (stall && (stat_stall_q != '1)) stat_stall_d = stat_stall_q + 32'd1;
    if (any_fwd && (stat_fwd_q != '1)) stat_fwd_d = stat_fwd_q + 32'd1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stat_stall_q <= '0;
      stat_fwd_q   <= '0;
    end else begin
      stat_stall_q <= stat_stall_d;
      stat_fwd_q   <= stat_fwd_d;
    end
  end

  assign stat_stall_cnt = stat_stall_q;
  assign stat_fwd_cnt   = stat_fwd_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// tb/tb_hazard_scoreboard_unit.sv - directed and randomized checks against a behavioural model
module tb_hazard_scoreboard_unit;

  localparam int NST  = 2;
  localparam int RW   = 5;
  localparam int SELW = 2;
  localparam int TMO  = 40;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic [RW-1:0]     dx_rs, dx_rt, dx_rd, md_rd_o;
  logic              dx_rs_used, dx_rt_used, dx_wr_valid, md_issue, md_done;
  logic [NST-1:0]    wr_valid, wr_ovf, wr_is_load;
  logic [NST*RW-1:0] wr_addr;
  logic [SELW-1:0]   fwd_sel_rs, fwd_sel_rt;
  logic              stall, md_busy, md_timeout;
`ifdef HAZARD_STATS_EN
  logic [31:0]       stat_stall_cnt, stat_fwd_cnt;
`endif

  int tests_run = 0;
  int fails     = 0;
  int cyc       = 0;

  // Model: at most one mult/div outstanding, so "pending" is just its owner while busy.
  bit m_busy, m_pulse;
  int m_owner, m_rd, m_issue_cyc;

  always #5 clock = ~clock;

  hazard_scoreboard_unit dut (
    .clock(clock), .reset_n(reset_n),
    .dx_rs(dx_rs), .dx_rt(dx_rt), .dx_rs_used(dx_rs_used), .dx_rt_used(dx_rt_used),
    .dx_wr_valid(dx_wr_valid), .dx_rd(dx_rd), .md_issue(md_issue), .md_done(md_done),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_ovf(wr_ovf), .wr_is_load(wr_is_load),
    .fwd_sel_rs(fwd_sel_rs), .fwd_sel_rt(fwd_sel_rt), .stall(stall),
    .md_rd_o(md_rd_o), .md_busy(md_busy), .md_timeout(md_timeout)
`ifdef HAZARD_STATS_EN
    , .stat_stall_cnt(stat_stall_cnt), .stat_fwd_cnt(stat_fwd_cnt)
`endif
  );

  function automatic bit m_pending(int r);
    return m_busy && (r != 0) && (r == m_owner);
  endfunction

  function automatic int exp_sel(int op, bit used, output bit lu);
    lu = 1'b0;
    if (!used) return 0;
    for (int k = 1; k <= NST; k++) begin
      int a;
      a = wr_ovf[k-1] ? 30 : int'(wr_addr[(k-1)*RW +: RW]);
      if (wr_valid[k-1] && a != 0 && a == op) begin
        if (k == 1 && wr_is_load[0]) begin
          lu = 1'b1;
          return 0;
        end
        return k;
      end
    end
    return 0;
  endfunction

  function automatic bit exp_stall();
    bit la, lb;
    int s;
    s = exp_sel(int'(dx_rs), dx_rs_used, la);
    s = exp_sel(int'(dx_rt), dx_rt_used, lb);
    return la | lb | (dx_rs_used && m_pending(int'(dx_rs))) | (dx_rt_used && m_pending(int'(dx_rt)))
         | (dx_wr_valid && m_pending(int'(dx_rd))) | (md_issue && m_busy);
  endfunction

  task automatic model_reset();
    m_busy = 0; m_pulse = 0; m_owner = 0; m_rd = 0; m_issue_cyc = 0;
  endtask

  task automatic clear_inputs();
    dx_rs = '0; dx_rt = '0; dx_rd = '0;
    dx_rs_used = 0; dx_rt_used = 0; dx_wr_valid = 0; md_issue = 0; md_done = 0;
    wr_valid = '0; wr_addr = '0; wr_ovf = '0; wr_is_load = '0;
  endtask

  task automatic set_stage(int k, bit v, int a, bit ovf, bit ld);
    wr_valid[k-1] = v;
    wr_addr[(k-1)*RW +: RW] = RW'(a);
    wr_ovf[k-1] = ovf;
    wr_is_load[k-1] = ld;
  endtask

  task automatic tick();
    bit st, nb, np;
    int no, nic;
    st = exp_stall();
    nb = m_busy; np = 0; no = m_owner; nic = m_issue_cyc;
    if (!m_busy) begin
      if (md_issue && !st && dx_rd != 0) begin
        nb = 1; no = int'(dx_rd); nic = cyc;
      end
    end else if (md_done) begin
      nb = 0;
    end else if (cyc - m_issue_cyc == TMO) begin
      nb = 0; np = 1;
    end
    @(posedge clock);
    #1;
    m_busy = nb; m_pulse = np; m_owner = no; m_rd = no; m_issue_cyc = nic;
    cyc++;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset_n = 0;
    model_reset();
    repeat (2) @(posedge clock);
    #1 reset_n = 1;
    #2;
    tests_run++;
    if ({md_busy, md_timeout, md_rd_o, stall, fwd_sel_rs, fwd_sel_rt} !== '0) begin
      fails++;
      $display("FAIL reset_state got busy=%0b tmo=%0b rd=%0d stall=%0b rs=%0d rt=%0d want all 0",
               md_busy, md_timeout, md_rd_o, stall, fwd_sel_rs, fwd_sel_rt);
    end
  endtask

  task automatic test_bypass();
    clear_inputs();
    set_stage(1, 1, 5, 0, 0);
    dx_rs = 5; dx_rs_used = 1;
    #2;
    tests_run++;
    if (fwd_sel_rs !== 2'd1 || stall !== 1'b0) begin
      fails++; $display("FAIL bypass_xm got sel=%0d stall=%0b want 1/0", fwd_sel_rs, stall);
    end
    set_stage(2, 1, 5, 0, 0);
    #2;
    tests_run++;
    if (fwd_sel_rs !== 2'd1) begin
      fails++; $display("FAIL bypass_nearest got %0d want 1", fwd_sel_rs);
    end
    set_stage(1, 0, 5, 0, 0);
    #2;
    tests_run++;
    if (fwd_sel_rs !== 2'd2) begin
      fails++; $display("FAIL bypass_mw got %0d want 2", fwd_sel_rs);
    end
    dx_rs_used = 0;
    #2;
    tests_run++;
    if (fwd_sel_rs !== 2'd0) begin
      fails++; $display("FAIL bypass_unused got %0d want 0", fwd_sel_rs);
    end
    tick();
  endtask

  task automatic test_ovf();
    clear_inputs();
    set_stage(1, 1, 7, 1, 0);
    dx_rt = 30; dx_rt_used = 1;
    #2;
    tests_run++;
    if (fwd_sel_rt !== 2'd1) begin
      fails++; $display("FAIL ovf_r30 got %0d want 1", fwd_sel_rt);
    end
    dx_rt = 7;
    #2;
    tests_run++;
    if (fwd_sel_rt !== 2'd0) begin
      fails++; $display("FAIL ovf_r7 got %0d want 0", fwd_sel_rt);
    end
    tick();
  endtask

  task automatic test_load_use();
    clear_inputs();
    set_stage(1, 1, 4, 0, 1);
    dx_rs = 4; dx_rs_used = 1;
    #2;
    tests_run++;
    if (stall !== 1'b1 || fwd_sel_rs !== 2'd0) begin
      fails++; $display("FAIL load_use got stall=%0b sel=%0d want 1/0", stall, fwd_sel_rs);
    end
    tick();
    set_stage(1, 0, 0, 0, 0);
    set_stage(2, 1, 4, 0, 1);
    #2;
    tests_run++;
    if (stall !== 1'b0 || fwd_sel_rs !== 2'd2) begin
      fails++; $display("FAIL load_next got stall=%0b sel=%0d want 0/2", stall, fwd_sel_rs);
    end
    tick();
  endtask

  task automatic test_md_stall();
    clear_inputs();
    md_issue = 1; dx_rd = 9;
    tick();
    md_issue = 0; dx_rd = 10; dx_wr_valid = 1; dx_rs = 9; dx_rs_used = 1;
    #2;
    tests_run++;
    if (md_busy !== 1'b1 || md_rd_o !== 5'd9) begin
      fails++; $display("FAIL md_issue got busy=%0b rd=%0d want 1/9", md_busy, md_rd_o);
    end
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (stall !== 1'b1) begin
        fails++; $display("FAIL md_raw_hold cycle %0d got %0b want 1", i, stall);
      end
      tick();
    end
    md_done = 1;
    #2;
    tests_run++;
    if (stall !== 1'b1) begin
      fails++; $display("FAIL md_done_cycle got %0b want 1", stall);
    end
    tick();
    md_done = 0;
    #2;
    tests_run++;
    if (stall !== 1'b0 || md_busy !== 1'b0) begin
      fails++; $display("FAIL md_release got stall=%0b busy=%0b want 0/0", stall, md_busy);
    end
    tick();
  endtask

  task automatic test_timeout();
    int n;
    clear_inputs();
    md_issue = 1; dx_rd = 9;
    tick();
    n = 0;
    while (md_busy === 1'b1 && n < 100) begin
      md_issue = (n == 0); dx_rd = 12;
      #2;
      if (n == 0) begin
        tests_run++;
        if (stall !== 1'b1) begin
          fails++; $display("FAIL md_second_issue got stall=%0b want 1", stall);
        end
      end
      n++;
      tick();
    end
    md_issue = 0; dx_rd = 0; dx_rs = 9; dx_rs_used = 1;
    #2;
    tests_run++;
    if (n !== TMO || md_timeout !== 1'b1 || stall !== 1'b0) begin
      fails++; $display("FAIL md_timeout got busy_cycles=%0d pulse=%0b stall=%0b want %0d/1/0",
                        n, md_timeout, stall, TMO);
    end
    tick();
    tests_run++;
    if (md_timeout !== 1'b0 || md_busy !== 1'b0) begin
      fails++; $display("FAIL md_timeout_pulse got pulse=%0b busy=%0b want 0/0", md_timeout, md_busy);
    end
  endtask

  task automatic test_r0();
    clear_inputs();
    set_stage(1, 1, 0, 0, 1);
    set_stage(2, 1, 0, 0, 0);
    dx_wr_valid = 1; dx_rd = 0; dx_rs = 0; dx_rt = 0; dx_rs_used = 1; dx_rt_used = 1;
    md_issue = 1;
    #2;
    tests_run++;
    if (stall !== 1'b0 || fwd_sel_rs !== 2'd0 || fwd_sel_rt !== 2'd0) begin
      fails++; $display("FAIL r0_no_hazard got stall=%0b rs=%0d rt=%0d want 0/0/0",
                        stall, fwd_sel_rs, fwd_sel_rt);
    end
    tick();
    tests_run++;
    if (md_busy !== 1'b0) begin
      fails++; $display("FAIL r0_md_issue got busy=%0b want 0", md_busy);
    end
  endtask

  task automatic test_reset_mid_busy();
    clear_inputs();
    md_issue = 1; dx_rd = 11;
    tick();
    md_issue = 0; dx_rs = 11; dx_rs_used = 1;
    #1 reset_n = 0;
    #1;
    model_reset();
    tests_run++;
    if (md_busy !== 1'b0 || md_rd_o !== 5'd0 || stall !== 1'b0) begin
      fails++; $display("FAIL reset_mid_busy got busy=%0b rd=%0d stall=%0b want 0/0/0",
                        md_busy, md_rd_o, stall);
    end
    @(posedge clock);
    #1 reset_n = 1;
  endtask

  function automatic int pick_reg();
    int r;
    r = $urandom_range(0, 9);
    return (r > 7) ? 22 + r : r;
  endfunction

  task automatic test_random();
    bit la, lb;
    int es_rs, es_rt;
    clear_inputs();
    for (int i = 0; i < 400; i++) begin
      dx_rs = RW'(pick_reg()); dx_rt = RW'(pick_reg()); dx_rd = RW'(pick_reg());
      dx_rs_used = 1'($urandom); dx_rt_used = 1'($urandom); dx_wr_valid = 1'($urandom);
      md_issue = ($urandom_range(0, 3) == 0);
      md_done  = ($urandom_range(0, 19) == 0);
      for (int k = 1; k <= NST; k++)
        set_stage(k, 1'($urandom), pick_reg(), $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0);
      #2;
      es_rs = exp_sel(int'(dx_rs), dx_rs_used, la);
      es_rt = exp_sel(int'(dx_rt), dx_rt_used, lb);
      tests_run++;
      if (int'(fwd_sel_rs) != es_rs || int'(fwd_sel_rt) != es_rt || stall !== exp_stall()) begin
        fails++; $display("FAIL rand_comb cycle %0d got rs=%0d rt=%0d stall=%0b want %0d/%0d/%0b",
                          i, fwd_sel_rs, fwd_sel_rt, stall, es_rs, es_rt, exp_stall());
      end
      tests_run++;
      if (md_busy !== m_busy || md_timeout !== m_pulse || int'(md_rd_o) != m_rd) begin
        fails++; $display("FAIL rand_md cycle %0d got busy=%0b tmo=%0b rd=%0d want %0b/%0b/%0d",
                          i, md_busy, md_timeout, md_rd_o, m_busy, m_pulse, m_rd);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_ovf();
    test_load_use();
    test_md_stall();
    test_timeout();
    test_r0();
    test_reset_mid_busy();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
